// File: rtl/adc_pkg.sv
// Shared definitions for the ADC two-lane transmit and receive paths.
package adc_pkg;

    localparam int LANE_BITS = 8;
    localparam int WORD_BITS = 2 * LANE_BITS;
    localparam int CNT_W     = $clog2(LANE_BITS);

    typedef logic [WORD_BITS-1:0] word_t;
    typedef logic [LANE_BITS-1:0] lane_byte_t;
    typedef logic [CNT_W-1:0]     cnt_t;

    typedef enum logic [1:0] {
        PAT_DATA  = 2'b00,
        PAT_TRAIN = 2'b01,
        PAT_RAMP  = 2'b10,
        PAT_ZERO  = 2'b11
    } pattern_e;

endpackage

// File: rtl/adc_lane_tx_if.sv
// Sample stream into the lane transmitter (valid/ready, one 16-bit word per beat).
interface adc_lane_tx_if;
    import adc_pkg::*;

    word_t s_data;
    logic  s_valid;
    logic  s_ready;

    modport master (output s_data, output s_valid, input  s_ready);
    modport slave  (input  s_data, input  s_valid, output s_ready);

endinterface

// File: rtl/adc_lane_serializer.sv
// One lane: parallel-load, MSB-first shift register. Clear has priority over load.
module adc_lane_serializer
    import adc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       load,
    input  lane_byte_t din,
    output logic       sout
);

    lane_byte_t sr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_reg <= '0;
        end else if (clear) begin
            sr_reg <= '0;
        end else if (load) begin
            sr_reg <= din;
        end else begin
            sr_reg <= {sr_reg[LANE_BITS-2:0], 1'b0};
        end
    end

    assign sout = sr_reg[LANE_BITS-1];

endmodule

// File: rtl/adc_lane_tx.sv
// Two-lane ADC emulator: 16-bit samples sent as two interleaved 8-bit serial lanes with a frame marker.
module adc_lane_tx
    import adc_pkg::*;
#(
    parameter logic [15:0] TRAIN_PAT = 16'hFF00,
    parameter logic [15:0] RAMP_INIT = 16'h0000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tx_en,
    input  logic [1:0]   pattern_sel,
    adc_lane_tx_if.slave s,
    output logic         ln0,
    output logic         ln1,
    output logic         frame,
    output logic [15:0]  underflow_cnt
);

    localparam cnt_t CNT_MAX = cnt_t'(LANE_BITS - 1);

    pattern_e   pat;
    cnt_t       bit_cnt_reg;
    cnt_t       bit_cnt_next;
    logic       frame_reg;
    logic       hold_full_reg;
    word_t      hold_data_reg;
    word_t      ramp_reg;
    logic [15:0] underflow_reg;

    logic       load_edge;
    logic       accept;
    logic       underflow_hit;
    word_t      word_next;
    lane_byte_t byte_odd;
    lane_byte_t byte_even;

    assign pat          = pattern_e'(pattern_sel);
    assign load_edge    = tx_en & (bit_cnt_reg == CNT_MAX);
    assign bit_cnt_next = bit_cnt_reg + cnt_t'(1);

    // Ready may be high on the load edge even when full: the held word leaves as the new one arrives.
    assign s.s_ready = rst_n & (pat == PAT_DATA) & (~hold_full_reg | load_edge);
    assign accept    = s.s_valid & s.s_ready;

    always_comb begin
        word_next     = '0;
        underflow_hit = 1'b0;
        case (pat)
            PAT_DATA: begin
                if (hold_full_reg) begin
                    word_next = hold_data_reg;
                end else begin
                    word_next     = TRAIN_PAT;
                    underflow_hit = 1'b1;
                end
            end
            PAT_TRAIN: word_next = TRAIN_PAT;
            PAT_RAMP:  word_next = ramp_reg;
            default:   word_next = '0;
        endcase
    end

    // Odd word bits feed lane 1, even bits lane 0, both MSB first.
    generate
        for (genvar gi = 0; gi < LANE_BITS; gi++) begin : g_split
            assign byte_odd[LANE_BITS-1-gi]  = word_next[WORD_BITS-1-2*gi];
            assign byte_even[LANE_BITS-1-gi] = word_next[WORD_BITS-2-2*gi];
        end
    endgenerate

    adc_lane_serializer u_ser_ln1 (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (~tx_en),
        .load  (load_edge),
        .din   (byte_odd),
        .sout  (ln1)
    );

    adc_lane_serializer u_ser_ln0 (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (~tx_en),
        .load  (load_edge),
        .din   (byte_even),
        .sout  (ln0)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_reg   <= CNT_MAX;
            frame_reg     <= 1'b0;
            hold_full_reg <= 1'b0;
            hold_data_reg <= '0;
            ramp_reg      <= RAMP_INIT;
            underflow_reg <= '0;
        end else begin
            if (!tx_en) begin
                bit_cnt_reg <= CNT_MAX;
                frame_reg   <= 1'b0;
                ramp_reg    <= RAMP_INIT;
            end else begin
                bit_cnt_reg <= bit_cnt_next;
                frame_reg   <= ~bit_cnt_next[CNT_W-1];
                if (load_edge && pat == PAT_RAMP) begin
                    ramp_reg <= ramp_reg + 16'd1;
                end
                if (load_edge && underflow_hit && underflow_reg != 16'hFFFF) begin
                    underflow_reg <= underflow_reg + 16'd1;
                end
            end
            if (accept) begin
                hold_data_reg <= s.s_data;
            end
            hold_full_reg <= accept | (hold_full_reg & ~(load_edge & (pat == PAT_DATA)));
        end
    end

    assign frame         = frame_reg;
    assign underflow_cnt = underflow_reg;

endmodule

// File: tb/tb_adc_lane_tx.sv
// Directed plus randomized checks of adc_lane_tx against a word-level behavioural model.
module tb_adc_lane_tx;
    import adc_pkg::*;

    localparam logic [15:0] TRAIN = 16'hFF00;
    localparam logic [15:0] RINIT = 16'h0000;

    logic        clk;
    logic        rst_n;
    logic        tx_en;
    logic [1:0]  pat;
    logic        ln0;
    logic        ln1;
    logic        frame;
    logic [15:0] underflow_cnt;

    adc_lane_tx_if sif ();

    adc_lane_tx #(.TRAIN_PAT(TRAIN), .RAMP_INIT(RINIT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tx_en         (tx_en),
        .pattern_sel   (pat),
        .s             (sif.slave),
        .ln0           (ln0),
        .ln1           (ln1),
        .frame         (frame),
        .underflow_cnt (underflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Model: current word, bit-time within it, one-entry hold, ramp value, underflow count.
    logic [15:0] m_word, m_hold, m_ramp, m_uf;
    int          m_t;
    bit          m_hf, m_live, m_last_acc;
    int          cyc = 0;
    int          acc_cyc[$];
    logic [15:0] rx_q[$];
    logic [15:0] rx_word;
    logic [7:0]  cap1, cap0, capf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_word = '0; m_hold = '0; m_ramp = RINIT; m_uf = '0;
        m_t = 7; m_hf = 0; m_live = 0; m_last_acc = 0;
    endtask

    task automatic cycle();
        bit rdy, acc;
        #1;
        rdy = (pat == PAT_DATA) && (!m_hf || (tx_en && m_t == 7));
        chk("s_ready", sif.s_ready, rdy);
        acc = sif.s_valid && rdy;
        @(posedge clk);
        if (!tx_en) begin
            m_t = 7; m_word = '0; m_ramp = RINIT; m_live = 0;
        end else if (m_t == 7) begin
            case (pat)
                PAT_DATA: begin
                    if (m_hf) begin
                        m_word = m_hold; m_hf = 0;
                    end else begin
                        m_word = TRAIN;
                        if (m_uf != 16'hFFFF) m_uf = m_uf + 1;
                    end
                end
                PAT_TRAIN: m_word = TRAIN;
                PAT_RAMP: begin
                    m_word = m_ramp; m_ramp = m_ramp + 1;
                end
                default: m_word = '0;
            endcase
            m_t = 0; m_live = 1;
        end else begin
            m_t++;
        end
        if (acc) begin
            m_hold = sif.s_data; m_hf = 1; acc_cyc.push_back(cyc);
        end
        m_last_acc = acc;
        cyc++;
        #1;
        chk("ln1",   ln1,   m_live ? m_word[15-2*m_t] : 1'b0);
        chk("ln0",   ln0,   m_live ? m_word[14-2*m_t] : 1'b0);
        chk("frame", frame, m_live && m_t < 4);
        chk("underflow_cnt", underflow_cnt, m_uf);
        cap1 = {cap1[6:0], ln1};
        cap0 = {cap0[6:0], ln0};
        capf = {capf[6:0], frame};
        if (m_live) begin
            rx_word[15-2*m_t] = ln1;
            rx_word[14-2*m_t] = ln0;
            if (m_t == 7) rx_q.push_back(rx_word);
        end
    endtask

    initial begin
        logic [15:0] smp[3];
        int idx;
        rst_n = 1'b0; tx_en = 1'b0; pat = PAT_DATA;
        sif.s_valid = 1'b0; sif.s_data = '0;
        rx_word = '0; cap1 = '0; cap0 = '0; capf = '0;
        model_reset();

        // Reset state, including s_ready held low by reset
        #12;
        chk("rst_ln0", ln0, 0);
        chk("rst_ln1", ln1, 0);
        chk("rst_frame", frame, 0);
        chk("rst_uf", underflow_cnt, 0);
        chk("rst_ready", sif.s_ready, 0);
        rst_n = 1'b1;

        // Single sample 16'hA5C3, buffered while disabled
        sif.s_valid = 1'b1; sif.s_data = 16'hA5C3;
        cycle();
        sif.s_valid = 1'b0;
        tx_en = 1'b1;
        repeat (8) cycle();
        chk("t1_ln1_byte", cap1, 8'hC9);
        chk("t1_ln0_byte", cap0, 8'h39);
        chk("t1_frame", capf, 8'hF0);

        // Three underflow words
        for (int w = 0; w < 3; w++) begin
            repeat (8) cycle();
            chk("t2_ln1_byte", cap1, 8'hF0);
            chk("t2_ln0_byte", cap0, 8'hF0);
        end
        chk("t2_uf", underflow_cnt, 3);

        // Back-to-back samples with s_valid held high
        smp[0] = 16'h0001; smp[1] = 16'h8000; smp[2] = 16'hFFFF;
        rx_q.delete(); acc_cyc.delete();
        idx = 0; sif.s_valid = 1'b1; sif.s_data = smp[0];
        for (int c = 0; c < 40 && idx < 3; c++) begin
            cycle();
            if (m_last_acc) begin
                idx++;
                if (idx < 3) sif.s_data = smp[idx];
                else sif.s_valid = 1'b0;
            end
        end
        chk("t3_all_accepted", idx, 3);
        repeat (15) cycle();
        chk("t3_words", rx_q.size(), 4);
        if (rx_q.size() == 4) begin
            for (int i = 0; i < 3; i++) chk("t3_rx_word", rx_q[i+1], smp[i]);
        end
        if (acc_cyc.size() == 3) begin
            chk("t3_gap0", acc_cyc[1] - acc_cyc[0], 8);
            chk("t3_gap1", acc_cyc[2] - acc_cyc[1], 8);
        end

        // RAMP, one disabled cycle, RAMP again
        pat = PAT_RAMP; rx_q.delete();
        repeat (32) cycle();
        chk("t4_words_a", rx_q.size(), 4);
        for (int i = 0; i < rx_q.size() && i < 4; i++) chk("t4_ramp_a", rx_q[i], i);
        tx_en = 1'b0;
        cycle();
        chk("t4_off_frame", frame, 0);
        chk("t4_off_ln1", ln1, 0);
        tx_en = 1'b1; rx_q.delete();
        repeat (16) cycle();
        chk("t4_words_b", rx_q.size(), 2);
        for (int i = 0; i < rx_q.size() && i < 2; i++) chk("t4_ramp_b", rx_q[i], i);

        // DATA -> ZERO at bit-time 3 with a sample held
        pat = PAT_DATA; rx_q.delete();
        sif.s_valid = 1'b1; sif.s_data = 16'h1234;
        cycle();
        sif.s_valid = 1'b0;
        repeat (3) cycle();
        pat = PAT_ZERO;
        repeat (12) cycle();
        pat = PAT_DATA;
        repeat (8) cycle();
        chk("t5_words", rx_q.size(), 3);
        if (rx_q.size() == 3) begin
            chk("t5_w0", rx_q[0], TRAIN);
            chk("t5_w1", rx_q[1], 16'h0000);
            chk("t5_w2", rx_q[2], 16'h1234);
        end

        // Asynchronous reset at bit-time 5
        repeat (6) cycle();
        chk("t6_bit_time", m_t, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_ln0", ln0, 0);
        chk("t6_ln1", ln1, 0);
        chk("t6_frame", frame, 0);
        chk("t6_uf", underflow_cnt, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) cycle();
        chk("t6_frame_word", capf, 8'hF0);
        chk("t6_ln1_word", cap1, 8'hF0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) pat = 2'($urandom_range(0, 3));
            tx_en = ($urandom_range(0, 31) != 0);
            sif.s_valid = 1'($urandom_range(0, 1));
            sif.s_data = 16'($urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
